// File: rtl/spram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spram_rr_arbiter
//
// This block is a two-requester round-robin arbiter and access sequencer. It
// sits in front of a single-port synchronous RAM with 1-cycle registered read
// latency. When a requester wins a grant, its command is latched. The RAM port
// is then driven only from registers, so the two masters never collide on the
// port.
//
// Transaction flow:
//   IDLE   -> ACCESS : grant edge. ram_en/ram_we/ram_addr/ram_wdata are loaded
//                      from the winner.
//   ACCESS -> IDLE   : the RAM performs the write on this edge, and the ack
//                      pulse is issued.
//   ACCESS -> RDCAP  : the RAM performs the read on this edge.
//   RDCAP  -> IDLE   : ram_rdata is captured into rdata, and the ack pulse is
//                      issued.
//
// IDLE does not grant while an ack is still high. This gives the requester
// that just completed a full cycle to drop its request.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN, N=0,1 : request, write(1)/read(0), address, data
//   ackN               : one-cycle completion pulse to requester N
//   rdata              : last read data; held until the next read completes
//   busy               : high whenever the sequencer is not in IDLE
//   ram_en/ram_we/ram_addr/ram_wdata : registered RAM port
//   ram_rdata          : RAM data_out
//   gnt_cnt0/gnt_cnt1  : saturating grant counters (only when
//                        SPRAM_ARB_STATS_EN is defined)
//
// Optional feature macro: SPRAM_ARB_STATS_EN
// ---------------------------------------------------------------------------
module spram_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
`ifdef SPRAM_ARB_STATS_EN
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1,
`endif
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                last_gnt, last_gnt_nxt;
  logic                gnt_id, gnt_id_nxt;
  logic                ack0_nxt, ack1_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic                ram_en_nxt, ram_we_nxt;
  logic [ADDR_W-1:0]   ram_addr_nxt;
  logic [DATA_W-1:0]   ram_wdata_nxt;
  logic                can_grant;
  logic                winner;

  // A new grant is blocked during the ack cycle of the previous transaction.
  assign can_grant = (req0 | req1) & ~(ack0 | ack1);
  // With both requesting, the side that did not win last time wins now.
  assign winner    = (req0 && req1) ? ~last_gnt : req1;
  assign busy      = (state != IDLE);

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    gnt_id_nxt    = gnt_id;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    rdata_nxt     = rdata;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;

    unique case (state)
      IDLE: begin
        ram_addr_nxt  = '0;
        ram_wdata_nxt = '0;
        if (can_grant) begin
          gnt_id_nxt    = winner;
          last_gnt_nxt  = winner;
          ram_en_nxt    = 1'b1;
          ram_we_nxt    = winner ? we1    : we0;
          ram_addr_nxt  = winner ? addr1  : addr0;
          ram_wdata_nxt = winner ? wdata1 : wdata0;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        // ram_we still holds the latched command direction during ACCESS.
        if (ram_we) begin
          ack0_nxt  = ~gnt_id;
          ack1_nxt  = gnt_id;
          state_nxt = IDLE;
        end else begin
          state_nxt = RDCAP;
        end
      end
      RDCAP: begin
        rdata_nxt = ram_rdata;
        ack0_nxt  = ~gnt_id;
        ack1_nxt  = gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // sees the values from before the edge, independent of statement order.
  // Asynchronous reset drops ram_en immediately, so an access is aborted
  // before the RAM can sample it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      rdata     <= rdata_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
    end
  end

`ifdef SPRAM_ARB_STATS_EN
  logic grant_now;
  assign grant_now = (state == IDLE) && can_grant;

  // The counters saturate at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant_now) begin
      if (!winner && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if ( winner && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: doc/spram_rr_arbiter.md
Name: spram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one sync_single_port_ram instance, 16x8, with 1-cycle registered read latency.
- Latches one command per transaction and drives the RAM port from registers.
- Returns an ack pulse plus read data to the winning requester.
- Lets a CPU-side master and a DMA-side master share the single port without collisions.

Parameters:
- ADDR_W, 4, RAM address width (depth 2^ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req0  in  1  requester 0 access request; held until ack0.
- we0  in  1  requester 0 write(1)/read(0); stable while req0=1.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1  same as requester 0, for requester 1.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes.
- busy  out  1  high when state is not IDLE.
- ram_en  out  1  RAM enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM data_out.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, last_gnt=1 (so requester 0 wins first).
  - ack0=ack1=0, rdata=0, busy=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- States are IDLE, ACCESS, RDCAP.
- IDLE, at edge k with any req high:
  - Winner: if only one req is high, that requester; if both are high, the requester != last_gnt.
  - Registers ram_en=1, ram_we, ram_addr, ram_wdata from the winner.
  - Stores winner id, sets last_gnt=winner, goes to ACCESS.
  - With no req, holds all ram_* outputs at 0.
- ACCESS, at edge k+1 (the RAM performs the operation on this edge):
  - ram_en=0, ram_we=0.
  - Write: ack[winner]=1 for one cycle, go to IDLE.
  - Read: go to RDCAP.
- RDCAP, at edge k+2: rdata<=ram_rdata, ack[winner]=1 for one cycle, go to IDLE.
- Latency from request sampled to ack: write 2 cycles, read 3 cycles.
- Back-to-back:
  - Next grant sampled at the edge after ack.
  - Minimum spacing is 3 cycles per write and 4 per read.
  - With both reqs held, grants strictly alternate 0,1,0,1.
- The command is latched at grant. Later changes to addr/we/wdata, or a req dropped mid-transaction, do not affect the access; the ack is still issued.
- A requester must deassert req in the cycle after ack (sampled low at the next IDLE edge) or it is re-granted when it is the only requester.
- ack0 and ack1 are never high together; at most one RAM access is in flight.
- Reset mid-transaction aborts immediately: ram_en drops asynchronously, no ack is issued, and the RAM is not written after reset assertion.
- ram_en is never high for more than one consecutive cycle.

Optional Feature:
- Macro SPRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 8 bits each, counting grants per requester.
  - Counters saturate at 255, reset to 0 on rst, and increment at the IDLE->ACCESS edge.
- When undefined: no counters and no ports; all other behaviour is identical.

Test Plan:
- Reset then single write: req0=1, we0=1, addr0=4'h3, wdata0=8'h5A → ram_en/ram_we high for exactly 1 cycle with ram_addr=3, ram_wdata=5A; ack0 pulses 2 cycles after sampling; busy falls with ack.
- Read-back: req1=1, we1=0, addr1=4'h3 → ack1 pulses 3 cycles after sampling with rdata=8'h5A; rdata holds 5A afterwards.
- Contention: req0 and req1 held continuously, 16 writes addr=i with data 8'hA0+i → grant order 0,1,0,1...; no cycle has ack0&ack1; readback of all 16 locations matches.
- Request drop and command latch: raise req0 (write addr 7, data C3), then drop req0 and change addr0 to 2 in the ACCESS cycle → RAM addr 7 holds C3, addr 2 is unchanged, ack0 still pulses.
- Reset mid-read: assert rst during RDCAP → no ack, rdata=0, busy=0 immediately; the next request after reset release is granted to requester 0 when both are pending.
- With SPRAM_ARB_STATS_EN: 300 grants to requester 0 → gnt_cnt0=255 (saturated); gnt_cnt1 counts exactly its grants; rst clears both counters.
